multiply_by_const_seq: RTL

Sequential, parametrised multiply-by-constant unit with an accumulate (Horner) mode, used by the reaction-time datapath to scale tick counts and to build decimal values digit by digit (acc*10 + digit). It replaces a one-shot combinational ×10 with a shift-add engine of configurable width and constant. Operands enter over a valid/ready handshake and the result leaves over a second one. An overflow flag replaces silent truncation.

---
 rtl/mult_pkg.sv | 13 +
 rtl/multiply_by_const_seq_if.sv | 25 ++
 rtl/multiply_by_const_seq_add_n.sv | 12 +
 rtl/multiply_by_const_seq.sv | 112 +++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the multiply-by-constant unit: controller states and the default datapath width.
package mult_pkg;

  localparam int DEF_WIDTH = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/multiply_by_const_seq_if.sv
// Operand and result handshakes for multiply_by_const_seq.
// Both channels are valid/ready: a beat transfers on a rising edge where valid and ready are both high;
// the producer holds its payload stable while valid is high and ready is low.
interface multiply_by_const_seq_if #(
  parameter int WIDTH = mult_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic             Mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Product;
  logic             Ovf;

  modport master (
    output in_valid, X, Mode, out_ready,
    input  in_ready, out_valid, Product, Ovf
  );

  modport slave (
    input  in_valid, X, Mode, out_ready,
    output in_ready, out_valid, Product, Ovf
  );
endinterface

// File: rtl/multiply_by_const_seq_add_n.sv
// add_n: WIDTH-bit unsigned adder with carry-in and carry-out, shared by the shift-add and addend steps.
module add_n #(
  parameter int WIDTH = mult_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/multiply_by_const_seq.sv
// Shift-add multiply-by-constant with Horner accumulate mode (Product = acc*CONST + X).
// Define MULT_SATURATE_EN to clamp overflowing results to all-ones instead of wrapping.
module multiply_by_const_seq
  import mult_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CONST      = 10,
  parameter int CONST_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  multiply_by_const_seq_if.slave bus,
  output state_t                 dbg_state,
  output logic [WIDTH-1:0]       dbg_acc
);
  localparam int IDX_W = (CONST_BITS > 1) ? $clog2(CONST_BITS) : 1;
  localparam logic [CONST_BITS-1:0] CONST_VEC = CONST_BITS'(CONST);
  localparam logic [IDX_W-1:0]      BIT_TOP   = IDX_W'(CONST_BITS - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] p, operand, addend, acc;
  logic [IDX_W-1:0] bit_idx;
  logic             ovf;

  logic [WIDTH-1:0] add_a, add_b, add_sum, p_add;
  logic             add_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.in_valid)       state_d = RUN;
      RUN:     if (bit_idx == '0)      state_d = ADD;
      ADD:                             state_d = DONE;
      DONE:    if (bus.out_ready)      state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // RUN doubles p and conditionally adds the operand; ADD folds in the latched addend.
  always_comb begin
    add_a = p;
    add_b = addend;
    if (state == RUN) begin
      add_a = {p[WIDTH-2:0], 1'b0};
      add_b = CONST_VEC[bit_idx] ? operand : '0;
    end
  end

  add_n #(.WIDTH(WIDTH)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef MULT_SATURATE_EN
  assign p_add = (ovf || add_cout) ? '1 : add_sum;
`else
  assign p_add = add_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p       <= '0;
      operand <= '0;
      addend  <= '0;
      bit_idx <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          operand <= bus.Mode ? acc : bus.X;
          addend  <= bus.Mode ? bus.X : '0;
          p       <= '0;
          bit_idx <= BIT_TOP;
          ovf     <= 1'b0;
        end
        RUN: begin
          p       <= add_sum;
          ovf     <= ovf | add_cout | p[WIDTH-1];
          bit_idx <= bit_idx - 1'b1;
        end
        ADD: begin
          p   <= p_add;
          ovf <= ovf | add_cout;
        end
        default: ;
      endcase
    end
  end

  // clr takes priority over capturing a completed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   acc <= '0;
    else if (clr)                              acc <= '0;
    else if (state == DONE && bus.out_ready)   acc <= p;
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.Product   = p;
  assign bus.Ovf       = ovf;
  assign dbg_state     = state;
  assign dbg_acc       = acc;
endmodule
